l2_mem_responder: RTL and testbench



---
 rtl/l2_mem_responder.sv | 123 ++++++++++++
 tb/tb_l2_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Main-memory responder for L2 refill/writeback: line-granular store with a
// fixed access latency and a single-cycle completion pulse.
module l2_mem_responder #(
    parameter int unsigned LINE_W = 512,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_L2_MEM,
    input  logic              write_L2_MEM,
    input  logic [IDX_W-1:0]  addr_L2_MEM,
    input  logic [LINE_W-1:0] write_data_L2_MEM,
    output logic [LINE_W-1:0] read_data_MEM_L2,
    output logic              ready_MEM_L2,
    output logic              busy_MEM_L2
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              mem_we;

    logic [LINE_W-1:0] mem_q [DEPTH];

    // Next-state and output logic; write wins over read when both are held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (write_L2_MEM) begin
                    addr_d  = addr_L2_MEM;
                    wdata_d = write_data_L2_MEM;
                    op_wr_d = 1'b1;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = S_BUSY;
                end else if (read_L2_MEM) begin
                    addr_d  = addr_L2_MEM;
                    op_wr_d = 1'b0;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Backing store; reset clears every line so an aborted write leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign read_data_MEM_L2 = rdata_q;
    assign ready_MEM_L2     = ready_q;
    assign busy_MEM_L2      = busy_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: stimulus pushes expected refill data,
// a negedge monitor pops and compares on every ready pulse.
module tb_l2_mem_responder;

    localparam int unsigned LINE_W = 512;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned LAT    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd;
    logic              wr;
    logic [IDX_W-1:0]  addr;
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rdata;
    logic              ready;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int busy_seen;
    logic [LINE_W-1:0] last_rd;
    logic [LINE_W-1:0] sb [$];
    logic prev_ready = 1'b0;

    always #5 clk = ~clk;

    l2_mem_responder #(.LINE_W(LINE_W), .IDX_W(IDX_W), .LAT(LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (rd),
        .write_L2_MEM      (wr),
        .addr_L2_MEM       (addr),
        .write_data_L2_MEM (wd),
        .read_data_MEM_L2  (rdata),
        .ready_MEM_L2      (ready),
        .busy_MEM_L2       (busy)
    );

    function automatic void check(input string name, input logic [LINE_W-1:0] act,
                                  input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every ready pulse must be single-cycle and expected.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (ready) begin
                check_int("ready_single_cycle", int'(prev_ready), 0);
                check_int("ready_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("read_data", rdata, sb.pop_front());
                end
            end
            prev_ready = ready;
        end
    end

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_seen++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_seen++;
        end
        check_int("return_idle", int'(busy), 0);
    endtask

    // One complete transaction; caller supplies the refill data a read must return.
    task automatic txn(input bit is_wr, input logic [IDX_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] exp);
        int lat;
        if (is_wr) begin
            sb.push_back(last_rd);
        end else begin
            sb.push_back(exp);
            last_rd = exp;
        end
        @(negedge clk);
        rd = !is_wr; wr = is_wr; addr = a; wd = d;
        @(posedge clk); #1;
        busy_seen = busy ? 1 : 0;
        wait_ready(lat);
        check_int("latency", lat, LAT);
        rd = 1'b0; wr = 1'b0;
        wait_idle();
    endtask

    initial begin
        int lat;
        int n;
        int k;
        int cyc;
        int t [3];

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; last_rd = '0;
        repeat (2) @(negedge clk);
        check("reset_read_data", rdata, '0);
        check_int("reset_ready", int'(ready), 0);
        check_int("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Cold read: zero data, LAT edges to ready, busy for LAT+1 cycles.
        txn(1'b0, 8'h05, '0, '0);
        check_int("busy_cycles", busy_seen, LAT + 1);

        txn(1'b1, 8'h10, {64{8'hA5}}, '0);
        check("rdata_kept_after_write", rdata, '0);
        txn(1'b0, 8'h10, '0, {64{8'hA5}});

        // Simultaneous write and read to one line: write first, then the held read.
        sb.push_back(last_rd);
        sb.push_back(LINE_W'(16'h1234));
        last_rd = LINE_W'(16'h1234);
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 8'h20; wd = LINE_W'(16'h1234);
        @(posedge clk); #1;
        wait_ready(lat);
        check_int("overlap_wr_latency", lat, LAT);
        check("overlap_wr_keeps_rdata", rdata, {64{8'hA5}});
        wr = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        check_int("overlap_rd_accept", int'(busy), 1);
        wait_ready(lat);
        check_int("overlap_rd_latency", lat, LAT);
        rd = 1'b0;
        wait_idle();

        // Inputs wiggled while busy must not affect the latched transaction.
        sb.push_back(last_rd);
        @(negedge clk);
        wr = 1'b1; addr = 8'h30; wd = LINE_W'(16'h0077);
        @(posedge clk); #1;
        addr = 8'h33; wd = LINE_W'(16'hFFFF);
        wait_ready(lat);
        check_int("wiggle_latency", lat, LAT);
        wr = 1'b0;
        wait_idle();
        txn(1'b0, 8'h30, '0, LINE_W'(16'h0077));
        txn(1'b0, 8'h33, '0, '0);

        // Reset two edges into a write: no pulse, no commit.
        @(negedge clk);
        wr = 1'b1; addr = 8'h40; wd = LINE_W'(16'hBEEF);
        @(posedge clk); #1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; wr = 1'b0;
        #2;
        check_int("abort_ready", int'(ready), 0);
        check_int("abort_busy", int'(busy), 0);
        check("abort_rdata", rdata, '0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready || busy) n++;
        end
        check_int("abort_quiet", n, 0);
        txn(1'b0, 8'h40, '0, '0);

        // Held read gives back-to-back transactions spaced LAT+2 edges apart.
        txn(1'b1, 8'h01, {64{8'hC3}}, '0);
        repeat (3) sb.push_back({64{8'hC3}});
        last_rd = {64{8'hC3}};
        @(negedge clk);
        rd = 1'b1; addr = 8'h01;
        cyc = 0; k = 0;
        while (k < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ready) begin
                t[k] = cyc;
                k++;
            end
        end
        rd = 1'b0;
        check_int("b2b_pulses", k, 3);
        check_int("b2b_spacing_0", t[1] - t[0], LAT + 2);
        check_int("b2b_spacing_1", t[2] - t[1], LAT + 2);
        wait_idle();

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
